// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse tracker: packet FSM states,
// byte0 field positions, frame length and the delta decode helper.
package ps2_pkg;

  typedef enum logic [1:0] {B0, B1, B2} pkt_state_t;

  localparam int unsigned BIT_LEFT   = 0;
  localparam int unsigned BIT_RIGHT  = 1;
  localparam int unsigned BIT_MIDDLE = 2;
  localparam int unsigned BIT_SYNC   = 3;
  localparam int unsigned BIT_XSIGN  = 4;
  localparam int unsigned BIT_YSIGN  = 5;
  localparam int unsigned BIT_XOVF   = 6;
  localparam int unsigned BIT_YOVF   = 7;

  localparam int unsigned FRAME_LEN = 11;
  localparam int unsigned DELTA_W   = 9;

  // Overflowed movement saturates to the extreme of its sign.
  function automatic logic signed [DELTA_W-1:0] make_delta(input logic sign, input logic ovf,
                                                           input logic [7:0] mag);
    if (ovf) return sign ? 9'h100 : 9'h0FF;
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ps2_byte_rx.sv
// PS/2 frame receiver: synchronises the raw lines, shifts in 11-bit frames on
// ps2_clk falling edges and flags bad start/parity/stop or a stalled frame.
module ps2_byte_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CW = $clog2(FRAME_LEN);

  logic [2:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    shift;
  logic          par_acc;
  logic [TW-1:0] idle_cnt;
  logic          fall;
  logic          bit_in;

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // Parity and stop are judged together at the stop bit so a bad frame yields one error.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync   <= '1;
      data_sync  <= '1;
      bit_cnt    <= '0;
      shift      <= '0;
      par_acc    <= 1'b0;
      idle_cnt   <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[1:0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (fall) begin
        idle_cnt <= '0;
        if (bit_cnt == '0) begin
          par_acc <= 1'b0;
          if (bit_in) byte_err <= 1'b1;
          else        bit_cnt  <= CW'(1);
        end else if (bit_cnt == CW'(FRAME_LEN - 1)) begin
          bit_cnt <= '0;
          if (par_acc && bit_in) begin
            byte_data  <= shift;
            byte_valid <= 1'b1;
          end else begin
            byte_err <= 1'b1;
          end
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          par_acc <= par_acc ^ bit_in;
          if (bit_cnt <= CW'(8)) shift <= {bit_in, shift[7:1]};
        end
      end else if (bit_cnt != '0) begin
        if (idle_cnt == TW'(TIMEOUT_CYC)) begin
          bit_cnt  <= '0;
          idle_cnt <= '0;
          byte_err <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte packets and integrates the movement
// into a clamped on-screen cursor position with button state and click pulses.
module ps2_mouse_tracker
  import ps2_pkg::*;
#(
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned INIT_X      = 320,
  parameter int unsigned INIT_Y      = 240,
  parameter int unsigned POS_W       = 12,
  parameter int unsigned SPEED_SHIFT = 0,
  parameter bit          Y_INVERT    = 1'b1,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  output logic [POS_W-1:0] x_pos,
  output logic [POS_W-1:0] y_pos,
  output logic             left_btn,
  output logic             right_btn,
  output logic             middle_btn,
  output logic             left_click,
  output logic             right_click,
  output logic             pkt_valid,
  output logic             sync_err
);

  localparam int unsigned AW = POS_W + 2;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic signed [AW-1:0] X_MAX = AW'(H_RES - 1);
  localparam logic signed [AW-1:0] Y_MAX = AW'(V_RES - 1);

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_err;
  pkt_state_t    state, state_next;
  logic [7:0]    byte0, byte1;
  logic [TW-1:0] pkt_idle;
  logic          timeout_c, store0_c, store1_c, commit_c, drop_c;

  logic signed [DELTA_W-1:0] dx9, dy9;
  logic signed [AW-1:0]      dx_s, dy_s, x_sum, y_sum;

  ps2_byte_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .byte_err  (rx_err)
  );

  function automatic logic [POS_W-1:0] clamp(input logic signed [AW-1:0] v,
                                             input logic signed [AW-1:0] vmax);
    if (v < 0)    return '0;
    if (v > vmax) return POS_W'(vmax);
    return POS_W'(v);
  endfunction

  assign timeout_c = (pkt_idle == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= B0;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    store0_c   = 1'b0;
    store1_c   = 1'b0;
    commit_c   = 1'b0;
    drop_c     = 1'b0;
    if (rx_err) begin
      state_next = B0;
    end else begin
      case (state)
        B0: if (rx_valid) begin
          if (rx_byte[BIT_SYNC]) begin
            store0_c   = 1'b1;
            state_next = B1;
          end else begin
            drop_c = 1'b1;
          end
        end
        B1: if (rx_valid) begin
          store1_c   = 1'b1;
          state_next = B2;
        end else if (timeout_c) begin
          state_next = B0;
        end
        B2: if (rx_valid) begin
          commit_c   = 1'b1;
          state_next = B0;
        end else if (timeout_c) begin
          state_next = B0;
        end
        default: state_next = B0;
      endcase
    end
  end

  // The third byte is consumed straight off the receiver, so commit lands one cycle after it.
  assign dx9   = make_delta(byte0[BIT_XSIGN], byte0[BIT_XOVF], byte1);
  assign dy9   = make_delta(byte0[BIT_YSIGN], byte0[BIT_YOVF], rx_byte);
  assign dx_s  = {{(AW - DELTA_W){dx9[DELTA_W-1]}}, dx9} << SPEED_SHIFT;
  assign dy_s  = {{(AW - DELTA_W){dy9[DELTA_W-1]}}, dy9} << SPEED_SHIFT;
  assign x_sum = $signed({2'b00, x_pos}) + dx_s;
  assign y_sum = Y_INVERT ? $signed({2'b00, y_pos}) - dy_s : $signed({2'b00, y_pos}) + dy_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_idle    <= '0;
      byte0       <= '0;
      byte1       <= '0;
      x_pos       <= POS_W'(INIT_X);
      y_pos       <= POS_W'(INIT_Y);
      left_btn    <= 1'b0;
      right_btn   <= 1'b0;
      middle_btn  <= 1'b0;
      left_click  <= 1'b0;
      right_click <= 1'b0;
      pkt_valid   <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pkt_idle    <= (state == B0 || rx_valid) ? '0 : pkt_idle + TW'(1);
      left_click  <= 1'b0;
      right_click <= 1'b0;
      pkt_valid   <= commit_c;
      sync_err    <= rx_err | drop_c;
      if (store0_c) byte0 <= rx_byte;
      if (store1_c) byte1 <= rx_byte;
      if (commit_c) begin
        x_pos       <= clamp(x_sum, X_MAX);
        y_pos       <= clamp(y_sum, Y_MAX);
        left_btn    <= byte0[BIT_LEFT];
        right_btn   <= byte0[BIT_RIGHT];
        middle_btn  <= byte0[BIT_MIDDLE];
        left_click  <= byte0[BIT_LEFT] & ~left_btn;
        right_click <= byte0[BIT_RIGHT] & ~right_btn;
      end
    end
  end

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Scoreboard bench for ps2_mouse_tracker: directed PS/2 packets push expected
// events; per-DUT monitors pop and compare on every pkt_valid / sync_err pulse.
module tb_ps2_mouse_tracker;

  localparam int unsigned TMO = 200;

  typedef struct packed {
    logic        is_err;
    logic [11:0] x;
    logic [11:0] y;
    logic        l, r, m, lc, rc;
  } ev_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pc0 = 1'b1, pd0 = 1'b1, pc1 = 1'b1, pd1 = 1'b1;

  logic [11:0] x0, y0, x1, y1;
  logic l0, r0, m0, lc0, rc0, pv0, se0;
  logic l1, r1, m1, lc1, rc1, pv1, se1;

  ev_t q0[$];
  ev_t q1[$];
  int  vectors = 0;
  int  miscompares = 0;

  always #5 clk = ~clk;

  ps2_mouse_tracker #(.TIMEOUT_CYC(TMO)) dut0 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(pc0), .ps2_data(pd0),
    .x_pos(x0), .y_pos(y0), .left_btn(l0), .right_btn(r0), .middle_btn(m0),
    .left_click(lc0), .right_click(rc0), .pkt_valid(pv0), .sync_err(se0)
  );

  ps2_mouse_tracker #(.SPEED_SHIFT(2), .TIMEOUT_CYC(TMO)) dut1 (
    .clk(clk), .reset_n(reset_n), .ps2_clk(pc1), .ps2_data(pd1),
    .x_pos(x1), .y_pos(y1), .left_btn(l1), .right_btn(r1), .middle_btn(m1),
    .left_click(lc1), .right_click(rc1), .pkt_valid(pv1), .sync_err(se1)
  );

  task automatic score(input int id, input logic pv, input logic se, input ev_t act);
    ev_t e;
    bit  ok;
    vectors++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d unexpected_event: got pkt_valid=%0b sync_err=%0b x=%0d y=%0d, expected no event",
               id, pv, se, act.x, act.y);
    end else begin
      e  = (id == 0) ? q0.pop_front() : q1.pop_front();
      ok = e.is_err ? (se && !pv) : (pv && !se && act == e);
      if (!ok) begin
        miscompares++;
        $display("FAIL dut%0d event: got pv=%0b se=%0b x=%0d y=%0d lrm=%b%b%b clicks=%b%b, expected err=%0b x=%0d y=%0d lrm=%b%b%b clicks=%b%b",
                 id, pv, se, act.x, act.y, act.l, act.r, act.m, act.lc, act.rc,
                 e.is_err, e.x, e.y, e.l, e.r, e.m, e.lc, e.rc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (pv0 || se0) score(0, pv0, se0, {se0, x0, y0, l0, r0, m0, lc0, rc0});
    if (pv1 || se1) score(1, pv1, se1, {se1, x1, y1, l1, r1, m1, lc1, rc1});
  end

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  task automatic ps2_bit(input bit sel, input logic b);
    if (sel) pd1 = b; else pd0 = b;
    repeat (4) @(posedge clk);
    if (sel) pc1 = 1'b0; else pc0 = 1'b0;
    repeat (4) @(posedge clk);
    if (sel) pc1 = 1'b1; else pc0 = 1'b1;
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(sel, f[i]);
    if (sel) pd1 = 1'b1; else pd0 = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic expect_pkt(input bit sel, input int x, input int y,
                            input logic l, input logic r, input logic m,
                            input logic lc, input logic rc);
    ev_t e;
    e = {1'b0, 12'(x), 12'(y), l, r, m, lc, rc};
    if (sel) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic expect_err(input bit sel);
    ev_t e;
    e = '0;
    e.is_err = 1'b1;
    if (sel) q1.push_back(e); else q0.push_back(e);
  endtask

  task automatic wait_drain(input bit sel);
    for (int i = 0; i < 100; i++) begin
      if ((sel ? q1.size() : q0.size()) == 0) break;
      @(posedge clk);
    end
    if ((sel ? q1.size() : q0.size()) != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL dut%0d drain_timeout: %0d expected events never seen, expected 0 pending",
               sel, sel ? q1.size() : q0.size());
      if (sel) q1.delete(); else q0.delete();
    end
  endtask

  task automatic send_pkt(input bit sel, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(sel, b0, 1'b0, 11);
    send_byte(sel, b1, 1'b0, 11);
    send_byte(sel, b2, 1'b0, 11);
    wait_drain(sel);
  endtask

  task automatic check_reset_values();
    check_now("reset_x0", 32'(x0), 32'd320);
    check_now("reset_y0", 32'(y0), 32'd240);
    check_now("reset_flags0", 32'({l0, r0, m0, lc0, rc0, pv0, se0}), 32'd0);
    check_now("reset_x1", 32'(x1), 32'd320);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // Basic move, then walk to the right edge and exercise left click edge detection.
    expect_pkt(0, 325, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h05, 8'h03);
    expect_pkt(0, 580, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'hFF, 8'h00);
    expect_pkt(0, 635, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h37, 8'h00);
    expect_pkt(0, 639, 237, 1, 0, 0, 1, 0); send_pkt(0, 8'h09, 8'h0A, 8'h00);
    expect_pkt(0, 639, 237, 1, 0, 0, 0, 0); send_pkt(0, 8'h09, 8'h0A, 8'h00);

    // Negative moves down to the left edge, then clamp at 0.
    expect_pkt(0, 383, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h18, 8'h00, 8'h00);
    expect_pkt(0, 127, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h18, 8'h00, 8'h00);
    expect_pkt(0,   5, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h18, 8'h86, 8'h00);
    expect_pkt(0,   0, 237, 0, 0, 0, 0, 0); send_pkt(0, 8'h18, 8'hF0, 8'h00);

    // Out-of-sync byte dropped, then a normal packet.
    expect_err(0);
    send_byte(0, 8'h00, 1'b0, 11);
    expect_pkt(0, 1, 236, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h01, 8'h01);

    // Bad parity on byte1 aborts the packet.
    expect_err(0);
    send_byte(0, 8'h08, 1'b0, 11);
    send_byte(0, 8'h03, 1'b1, 11);
    wait_drain(0);
    expect_pkt(0, 4, 234, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h03, 8'h02);

    // Right/middle buttons, overflow saturation and y clamping in both directions.
    expect_pkt(0,   4, 234, 0, 1, 1, 0, 1); send_pkt(0, 8'h0E, 8'h00, 8'h00);
    expect_pkt(0, 259, 234, 0, 0, 0, 0, 0); send_pkt(0, 8'h48, 8'h00, 8'h00);
    expect_pkt(0, 259, 479, 0, 0, 0, 0, 0); send_pkt(0, 8'hA8, 8'h00, 8'h00);
    expect_pkt(0, 259, 224, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h00, 8'hFF);
    expect_pkt(0, 259,   0, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h00, 8'hFF);

    // Stalled packet is dropped silently; the following packet starts fresh.
    send_byte(0, 8'h08, 1'b0, 11);
    send_byte(0, 8'h01, 1'b0, 11);
    repeat (TMO + 50) @(posedge clk);
    expect_pkt(0, 261, 0, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h02, 8'h00);
    expect_pkt(0, 261, 1, 0, 0, 0, 0, 0); send_pkt(0, 8'h28, 8'h00, 8'hFF);

    // Reset in the middle of a frame: back to reset values, no stray pulses after.
    for (int i = 0; i < 5; i++) ps2_bit(0, (i == 4) ? 1'b1 : 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;
    repeat (TMO + 100) @(posedge clk);
    expect_pkt(0, 321, 239, 0, 0, 0, 0, 0); send_pkt(0, 8'h08, 8'h01, 8'h01);

    // Speed gain of 4 on the second instance.
    expect_pkt(1, 328, 240, 0, 0, 0, 0, 0); send_pkt(1, 8'h08, 8'h02, 8'h00);

    repeat (20) @(posedge clk);
    check_now("leftover_events", 32'(q0.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
